// File: rtl/data_mem_ctrl_pkg.sv
// Shared widths, write-buffer default depth and FSM encoding for the data
// memory controller.
package data_mem_ctrl_pkg;

  localparam int ADDR_W           = 7;
  localparam int DATA_W           = 32;
  localparam int WB_DEPTH_DEFAULT = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_WAIT = 2'd3
  } state_t;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Core-side load/store strobes plus backing-memory request channel.
// slave = the controller; master = the core and memory around it.
interface data_mem_ctrl_if;
  import data_mem_ctrl_pkg::*;

  logic              CEN;
  logic              WEN;
  logic              OEN;
  logic [ADDR_W-1:0] A;
  logic [DATA_W-1:0] Data2Mem;
  logic [DATA_W-1:0] ReadDataMem;
  logic              stall;
  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  CEN, WEN, OEN, A, Data2Mem, mem_ready, mem_rvalid, mem_rdata,
    output ReadDataMem, stall, mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output CEN, WEN, OEN, A, Data2Mem, mem_ready, mem_rvalid, mem_rdata,
    input  ReadDataMem, stall, mem_req, mem_wr, mem_addr, mem_wdata
  );

endinterface

// File: rtl/data_mem_ctrl_wb_fifo.sv
// Write buffer: circular FIFO of {addr, data} with an associative lookup that
// returns the youngest valid entry matching the probe address.
module wb_fifo
  import data_mem_ctrl_pkg::*;
#(
  parameter  int DEPTH = WB_DEPTH_DEFAULT,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_push,
  input  logic [ADDR_W-1:0] i_push_addr,
  input  logic [DATA_W-1:0] i_push_data,
  input  logic              i_pop,
  input  logic [ADDR_W-1:0] i_lookup_addr,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W-1:0] o_head_addr,
  output logic [DATA_W-1:0] o_head_data,
  output logic              o_hit,
  output logic [DATA_W-1:0] o_hit_data
);

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  logic [PTR_W-1:0]  w_idx;

  // Push after pop so a full-buffer push into the slot just freed stays valid.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (i_pop) begin
        r_head          <= r_head + PTR_W'(1);
        r_valid[r_head] <= 1'b0;
      end
      if (i_push) begin
        r_tail          <= r_tail + PTR_W'(1);
        r_valid[r_tail] <= 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_push) begin
      r_addr[r_tail] <= i_push_addr;
      r_data[r_tail] <= i_push_data;
    end
  end

  assign o_full      = (r_count == CNT_W'(DEPTH));
  assign o_empty     = (r_count == '0);
  assign o_head_addr = r_addr[r_head];
  assign o_head_data = r_data[r_head];

  // Scan oldest to youngest; later matches overwrite earlier ones.
  always_comb begin
    o_hit      = 1'b0;
    o_hit_data = '0;
    w_idx      = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_idx = r_head + PTR_W'(i);
      if (r_valid[w_idx] && (r_addr[w_idx] == i_lookup_addr)) begin
        o_hit      = 1'b1;
        o_hit_data = r_data[w_idx];
      end
    end
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Data memory controller: posted writes through a write buffer, loads served
// from the buffer on a hit or from backing memory on a miss.
//   state   | meaning
//   IDLE    | no memory request; pick read miss first, then drain
//   WR_REQ  | presenting buffer head as a write until mem_ready
//   RD_REQ  | presenting core address as a read until mem_ready
//   RD_WAIT | read accepted, waiting for mem_rvalid
module data_mem_ctrl
  import data_mem_ctrl_pkg::*;
#(
  parameter int WB_DEPTH = WB_DEPTH_DEFAULT
) (
  input logic            clk,
  input logic            rst_n,
  data_mem_ctrl_if.slave bus
);

  state_t            r_state;
  state_t            w_next;
  logic              w_wr_act;
  logic              w_rd_act;
  logic              w_rd_miss;
  logic              w_rd_done;
  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_hit;
  logic [DATA_W-1:0] w_hit_data;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic              w_mem_req;
  logic              w_mem_wr;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic              w_stall;
  logic [DATA_W-1:0] w_rdata;

  // A simultaneous write and read strobe is treated as a write only.
  assign w_wr_act  = !bus.CEN && !bus.WEN;
  assign w_rd_act  = !bus.CEN && !bus.OEN && bus.WEN;
  assign w_rd_miss = w_rd_act && !w_hit;
  assign w_rd_done = (r_state == RD_WAIT) && bus.mem_rvalid;
  assign w_pop     = (r_state == WR_REQ) && bus.mem_ready;
  assign w_push    = w_wr_act && (!w_full || w_pop);

  wb_fifo #(.DEPTH(WB_DEPTH)) u_wb (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_push        (w_push),
    .i_push_addr   (bus.A),
    .i_push_data   (bus.Data2Mem),
    .i_pop         (w_pop),
    .i_lookup_addr (bus.A),
    .o_full        (w_full),
    .o_empty       (w_empty),
    .o_head_addr   (w_head_addr),
    .o_head_data   (w_head_data),
    .o_hit         (w_hit),
    .o_hit_data    (w_hit_data)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    w_mem_req   = 1'b0;
    w_mem_wr    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    case (r_state)
      IDLE: begin
        if (w_rd_miss)     w_next = RD_REQ;
        else if (!w_empty) w_next = WR_REQ;
      end
      WR_REQ: begin
        w_mem_req   = 1'b1;
        w_mem_wr    = 1'b1;
        w_mem_addr  = w_head_addr;
        w_mem_wdata = w_head_data;
        if (bus.mem_ready) w_next = IDLE;
      end
      RD_REQ: begin
        w_mem_req  = 1'b1;
        w_mem_addr = bus.A;
        if (bus.mem_ready) w_next = RD_WAIT;
      end
      RD_WAIT: begin
        if (bus.mem_rvalid) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_stall = (w_wr_act && w_full && !w_pop) || (w_rd_miss && !w_rd_done);
  assign w_rdata = !w_rd_act ? '0 :
                   w_hit     ? w_hit_data :
                   w_rd_done ? bus.mem_rdata : '0;

  // Reset is synchronous, so outputs are forced quiet while rst_n is low.
  assign bus.mem_req     = rst_n && w_mem_req;
  assign bus.mem_wr      = rst_n && w_mem_wr;
  assign bus.mem_addr    = rst_n ? w_mem_addr  : '0;
  assign bus.mem_wdata   = rst_n ? w_mem_wdata : '0;
  assign bus.stall       = rst_n && w_stall;
  assign bus.ReadDataMem = rst_n ? w_rdata : '0;

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL use a single clock and a reset that is synchronous and active-low.
REQ-002 Port clk, input, 1 bit: the single clock; every register updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-004 Port CEN, input, 1 bit: core chip enable, active-low; CEN equals OEN AND WEN.
REQ-005 Port WEN, input, 1 bit: core write strobe, active-low.
REQ-006 Port OEN, input, 1 bit: core read strobe, active-low.
REQ-007 Port A, input, 7 bits: core word address.
REQ-008 Port Data2Mem, input, 32 bits: core store data.
REQ-009 Port ReadDataMem, output, 32 bits: load data returned to the core.
REQ-010 Port stall, output, 1 bit: core freezes PC and register writeback and holds the request while stall is high.
REQ-011 Port mem_req, output, 1 bit: backing-memory request valid.
REQ-012 Port mem_wr, output, 1 bit: 1 selects a write request, 0 selects a read request.
REQ-013 Port mem_addr, output, 7 bits: backing-memory word address.
REQ-014 Port mem_wdata, output, 32 bits: backing-memory write data.
REQ-015 Port mem_ready, input, 1 bit: backing memory accepts the request in the cycle it is high.
REQ-016 Port mem_rvalid, input, 1 bit: mem_rdata is valid this cycle.
REQ-017 Port mem_rdata, input, 32 bits: backing-memory read data.
REQ-018 Parameter WB_DEPTH, default 4, power of two: number of write-buffer entries.

Function
REQ-019 The block SHALL hold writes in a FIFO write buffer of WB_DEPTH {addr, data} entries, with head and tail pointers that wrap modulo WB_DEPTH and a count of width log2(WB_DEPTH)+1.
REQ-020 A write (WEN=0) with the buffer not full SHALL push at the clock edge with stall=0, giving zero added latency.
REQ-021 A write with the buffer full SHALL raise stall; the push occurs on the first edge at which count < WB_DEPTH, including the edge on which a pop frees an entry.
REQ-022 If WEN=0 and OEN=0 occur together (illegal), the block SHALL treat the cycle as a write and ignore the read.
REQ-023 A read (OEN=0) whose A matches any valid buffer entry SHALL return the youngest matching entry's data on ReadDataMem combinationally, with stall=0.
REQ-024 A read miss SHALL raise stall until the cycle mem_rvalid=1; in that cycle ReadDataMem = mem_rdata and stall=0.
REQ-025 With no read active, ReadDataMem SHALL be 0.
REQ-026 The FSM SHALL have the states IDLE, WR_REQ, RD_REQ and RD_WAIT.
REQ-027 In IDLE: an active read miss SHALL go to RD_REQ; otherwise a non-empty buffer SHALL go to WR_REQ; otherwise the FSM stays in IDLE. A read has priority over draining.
REQ-028 In WR_REQ: mem_req=1, mem_wr=1, and mem_addr/mem_wdata = the head entry; on mem_ready the block SHALL pop and go to IDLE.
REQ-029 A read miss that arrives during WR_REQ SHALL wait for that write to be accepted; a write is never aborted.
REQ-030 In RD_REQ: mem_req=1, mem_wr=0, mem_addr=A; on mem_ready the FSM SHALL go to RD_WAIT.
REQ-031 In RD_WAIT: mem_req=0; on mem_rvalid the FSM SHALL go to IDLE.
REQ-032 mem_addr, mem_wdata and mem_wr SHALL stay stable while mem_req=1 and mem_ready=0.
REQ-033 mem_rvalid outside RD_WAIT SHALL be ignored.
REQ-034 A push and a pop in the same cycle SHALL leave count unchanged.
REQ-035 With the buffer empty and a write arriving, the block SHALL push first; the drain starts no earlier than the next cycle.
REQ-036 In IDLE with no request, mem_req SHALL be 0, mem_wr 0, mem_addr 0 and mem_wdata 0.

Reset
REQ-037 rst_n=0 at an edge SHALL force state IDLE, clear the head/tail pointers and count, and clear all entry valid bits.
REQ-038 During reset: mem_req=0, mem_wr=0, mem_addr=0, mem_wdata=0, stall=0, ReadDataMem=0.
REQ-039 Reset mid-transaction SHALL discard any in-flight request and buffered writes; a later mem_rvalid SHALL be ignored per REQ-033.

Structure
REQ-040 The shared package SHALL hold the FSM state encoding, the 7-bit address width, the 32-bit data width and the WB_DEPTH default.
REQ-041 The write buffer SHALL be one sub-module, wb_fifo, providing push/pop/full/empty and an associative youngest-match lookup port; the FSM and muxing stay in data_mem_ctrl.

Verification
REQ-042 Bench: after reset, write A=5 data 0xDEADBEEF with mem_ready held 0, then read A=5 -> stall=0 and ReadDataMem=0xDEADBEEF in the same cycle.
REQ-043 Bench: 5 back-to-back writes with mem_ready=0 -> stall=1 on the 5th write; set mem_ready=1 -> the 5th write is pushed on the pop edge and mem_addr follows FIFO order.
REQ-044 Bench: write A=3 data 1, then write A=3 data 2, then read A=3 -> returns 2 from the youngest entry.
REQ-045 Bench: read miss A=9 with mem_ready=1 and mem_rvalid 3 cycles later with mem_rdata 0x1234 -> stall high for 4 cycles, then ReadDataMem=0x1234.
REQ-046 Bench: read miss during WR_REQ with mem_ready held low 2 cycles -> the write is accepted first, then RD_REQ issues and mem_addr does not change before acceptance.
REQ-047 Bench: rst_n=0 in RD_WAIT with 2 entries buffered, then mem_rvalid=1 -> state IDLE, count 0, mem_req=0, stall=0.
